// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte valid/ready holding register; all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between D7 and the stop bit.
module uart_tx #(
    parameter int CLK_FREQ  = 65_000_000,
    parameter int BAUD_RATE = 9_600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TxD,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int         BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam logic [12:0] BAUD_LAST = 13'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [12:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg, shift_nxt;
    logic        txd_nxt, ready_nxt, done_nxt;
    logic        handshake, tick;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    assign handshake = tx_valid && tx_ready;
    assign tick      = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            // Held at zero while idle, so a handshake always starts a full start bit.
            baud_cnt  <= (state == IDLE || tick) ? 13'd0 : baud_cnt + 13'd1;
            bit_cnt   <= (state != DATA) ? 3'd0 : (tick ? bit_cnt + 3'd1 : bit_cnt);
`ifdef UART_TX_PARITY_EN
            if (handshake)
                parity_bit <= ^tx_data;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        case (state)
            IDLE: if (handshake) begin
                state_nxt = START;
                shift_nxt = tx_data;
            end
            START: if (tick) state_nxt = DATA;
            DATA: if (tick) begin
                shift_nxt = {1'b0, shift_reg[7:1]};
                if (bit_cnt == 3'd7)
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) state_nxt = STOP;
`endif
            STOP: if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so TxD never glitches.
    always_comb begin
        txd_nxt   = 1'b1;
        ready_nxt = 1'b0;
        done_nxt  = (state == STOP) && tick;
        case (state_nxt)
            IDLE:   ready_nxt = 1'b1;
            START:  txd_nxt   = 1'b0;
            DATA:   txd_nxt   = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_nxt   = parity_bit;
`endif
            STOP:   txd_nxt   = 1'b1;
            default: begin
                txd_nxt   = 1'b1;
                ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            TxD      <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            TxD      <= txd_nxt;
            tx_ready <= ready_nxt;
            tx_busy  <= ~ready_nxt;
            tx_done  <= done_nxt;
        end
    end

endmodule
